// File: rtl/mpsoc_msi_wb_slave_slice.sv
// -----------------------------------------------------------------------------
// mpsoc_msi_wb_slave_slice
//
// Registered Wishbone request/response slice. It sits between the arbiter's
// shared slave port and the downstream slave (or the address decoder). It
// breaks the combinational loop arbiter mux -> slave -> ack -> arbiter.
//
// Every access is issued downstream as an isolated classic single cycle,
// including each beat of a master burst. The master's cti/bte are accepted
// but have no effect. wbs_cti_o and wbs_bte_o are always classic (0).
//
// Build option:
//   MPSOC_MSI_WB_SLICE_TIMEOUT_EN
//     When defined, an access that gets no slave response within TIMEOUT
//     cycles of REQ is terminated with a bus error and a timeout_o pulse.
//     When undefined, REQ waits indefinitely and timeout_o is tied low.
//
// Parameters:
//   DW       data width
//   AW       address width
//   TIMEOUT  REQ cycles before a forced error (timeout build only), 1..65535
//
// Ports:
//   wb_clk_i, wb_rst_i          clock, synchronous active-high reset
//   wbm_* inputs                request from the arbiter (adr/dat/sel/we/cyc/stb/cti/bte)
//   wbm_dat_o/ack_o/err_o/rty_o registered response to the arbiter
//   wbs_* outputs               registered request to the slave (cti/bte constant 0)
//   wbs_dat_i/ack_i/err_i/rty_i response from the slave
//   timeout_o                   one-cycle pulse together with a timeout error
// -----------------------------------------------------------------------------
module mpsoc_msi_wb_slave_slice #(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,

  input  logic [AW-1:0] wbm_adr_i,
  input  logic [DW-1:0] wbm_dat_i,
  input  logic [3:0]    wbm_sel_i,
  input  logic          wbm_we_i,
  input  logic          wbm_cyc_i,
  input  logic          wbm_stb_i,
  input  logic [2:0]    wbm_cti_i,
  input  logic [1:0]    wbm_bte_i,
  output logic [DW-1:0] wbm_dat_o,
  output logic          wbm_ack_o,
  output logic          wbm_err_o,
  output logic          wbm_rty_o,

  output logic [AW-1:0] wbs_adr_o,
  output logic [DW-1:0] wbs_dat_o,
  output logic [3:0]    wbs_sel_o,
  output logic          wbs_we_o,
  output logic          wbs_cyc_o,
  output logic          wbs_stb_o,
  output logic [2:0]    wbs_cti_o,
  output logic [1:0]    wbs_bte_o,
  input  logic [DW-1:0] wbs_dat_i,
  input  logic          wbs_ack_i,
  input  logic          wbs_err_i,
  input  logic          wbs_rty_i,

  output logic          timeout_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t        state_q;

  logic [AW-1:0] adr_q;
  logic [DW-1:0] wdat_q;
  logic [3:0]    sel_q;
  logic          we_q;
  logic          cyc_q;
  logic          stb_q;

  logic [DW-1:0] rdat_q;
  logic          ack_q;
  logic          err_q;
  logic          rty_q;

  // Any slave termination this cycle.
  logic          slv_resp_d;
  // Response flags decoded with priority err > rty > ack.
  logic          err_d;
  logic          rty_d;
  logic          ack_d;

  assign slv_resp_d = wbs_ack_i | wbs_err_i | wbs_rty_i;
  assign err_d      = wbs_err_i;
  assign rty_d      = ~wbs_err_i & wbs_rty_i;
  assign ack_d      = ~wbs_err_i & ~wbs_rty_i & wbs_ack_i;

  // Burst qualifiers are accepted but deliberately ignored: each beat becomes
  // its own classic access downstream.
  logic unused_burst_info;
  assign unused_burst_info = ^{wbm_cti_i, wbm_bte_i};

`ifdef MPSOC_MSI_WB_SLICE_TIMEOUT_EN
  // Counter value on the last REQ cycle before the access is given up.
  localparam logic [15:0] TOUT_LAST = 16'(TIMEOUT - 1);

  logic [15:0] cnt_q;
  // Set for the first RESP cycle of a timed-out access: the downstream cycle
  // is already dropped, and the error flag follows one cycle later.
  logic        tpend_q;
  logic        tout_q;
`else
  localparam int unused_timeout_param = TIMEOUT;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      adr_q   <= '0;
      wdat_q  <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      rdat_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rty_q   <= 1'b0;
`ifdef MPSOC_MSI_WB_SLICE_TIMEOUT_EN
      cnt_q   <= '0;
      tpend_q <= 1'b0;
      tout_q  <= 1'b0;
`endif
    end else begin
      // Master flags are single-cycle pulses; only RESP raises them.
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      rty_q  <= 1'b0;
`ifdef MPSOC_MSI_WB_SLICE_TIMEOUT_EN
      tout_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (wbm_cyc_i && wbm_stb_i) begin
            adr_q   <= wbm_adr_i;
            wdat_q  <= wbm_dat_i;
            sel_q   <= wbm_sel_i;
            we_q    <= wbm_we_i;
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
            state_q <= ST_REQ;
`ifdef MPSOC_MSI_WB_SLICE_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end

        ST_REQ: begin
          if (slv_resp_d) begin
            cyc_q <= 1'b0;
            stb_q <= 1'b0;
            if (wbm_cyc_i) begin
              rdat_q  <= wbs_dat_i;
              err_q   <= err_d;
              rty_q   <= rty_d;
              ack_q   <= ack_d;
              state_q <= ST_RESP;
            end else begin
              // Response collided with a master abort: swallow it.
              state_q <= ST_IDLE;
            end
          end else if (!wbm_cyc_i) begin
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
`ifdef MPSOC_MSI_WB_SLICE_TIMEOUT_EN
          else if (cnt_q == TOUT_LAST) begin
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            tpend_q <= 1'b1;
            state_q <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
`endif
        end

        ST_RESP: begin
`ifdef MPSOC_MSI_WB_SLICE_TIMEOUT_EN
          if (tpend_q) begin
            // Stay one more cycle so err and timeout_o appear together.
            tpend_q <= 1'b0;
            err_q   <= 1'b1;
            tout_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
          end
`else
          state_q <= ST_IDLE;
`endif
        end

        default: begin
          cyc_q   <= 1'b0;
          stb_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign wbm_dat_o = rdat_q;
  assign wbm_ack_o = ack_q;
  assign wbm_err_o = err_q;
  assign wbm_rty_o = rty_q;

  assign wbs_adr_o = adr_q;
  assign wbs_dat_o = wdat_q;
  assign wbs_sel_o = sel_q;
  assign wbs_we_o  = we_q;
  assign wbs_cyc_o = cyc_q;
  assign wbs_stb_o = stb_q;
  assign wbs_cti_o = 3'b000;
  assign wbs_bte_o = 2'b00;

`ifdef MPSOC_MSI_WB_SLICE_TIMEOUT_EN
  assign timeout_o = tout_q;
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: doc/mpsoc_msi_wb_slave_slice.md
Name: mpsoc_msi_wb_slave_slice

Overview:
Registered Wishbone request/response slice between the arbiter's shared slave port and the downstream slave, or the address decoder.
- Breaks the long combinational path: arbiter mux → slave → ack → arbiter.
- Converts every access, burst beats included, into an isolated classic single cycle.
- Optionally terminates hung accesses with a bus error after a timeout.

Parameters:
DW, 32, data width in bits
AW, 32, address width in bits
TIMEOUT, 255, cycles in REQ without a slave response before forced error (timeout build only); legal range 1..65535

Ports:
wb_clk_i  input  1  clock, all logic on rising edge
wb_rst_i  input  1  reset, synchronous, active-high
wbm_adr_i  input  AW  request address from arbiter
wbm_dat_i  input  DW  write data
wbm_sel_i  input  4  byte selects
wbm_we_i  input  1  write enable
wbm_cyc_i  input  1  cycle
wbm_stb_i  input  1  strobe
wbm_cti_i  input  3  cycle type (sampled, not forwarded)
wbm_bte_i  input  2  burst type (sampled, not forwarded)
wbm_dat_o  output  DW  registered read data
wbm_ack_o  output  1  registered ack
wbm_err_o  output  1  registered err
wbm_rty_o  output  1  registered rty
wbs_adr_o  output  AW  registered address
wbs_dat_o  output  DW  registered write data
wbs_sel_o  output  4  registered selects
wbs_we_o  output  1  registered we
wbs_cyc_o  output  1  registered cyc
wbs_stb_o  output  1  registered stb
wbs_cti_o  output  3  constant 3'b000 (classic)
wbs_bte_o  output  2  constant 2'b00
wbs_dat_i  input  DW  slave read data
wbs_ack_i  input  1  slave ack
wbs_err_i  input  1  slave err
wbs_rty_i  input  1  slave rty
timeout_o  output  1  one-cycle pulse when a timeout error is issued

Behaviour:
- Reset (wb_rst_i high at an edge):
  - state=IDLE.
  - All wbm_* and wbs_* outputs 0; timeout_o=0; counter=0.
  - Applies from any state; any in-flight access is dropped with no response to the master.
- State machine: IDLE, REQ, RESP.
- IDLE:
  - wbs_cyc_o=wbs_stb_o=0.
  - If wbm_cyc_i & wbm_stb_i: register adr/dat/sel/we, then → REQ.
  - wbs_cyc_o/stb_o=1 from the next cycle.
- REQ:
  - Outputs held stable.
  - If wbs_ack_i|wbs_err_i|wbs_rty_i:
    - Capture wbs_dat_i into wbm_dat_o.
    - Capture the response type, priority err > rty > ack.
    - Drop wbs_cyc_o/stb_o next cycle, → RESP.
  - If wbm_cyc_i=0 (master abort) with no slave response this cycle: drop wbs_cyc_o/stb_o next cycle, → IDLE, no master response.
  - A slave response coinciding with an abort is consumed and discarded, → IDLE.
- RESP:
  - Exactly one of wbm_ack_o/err_o/rty_o is high for exactly one cycle, → IDLE.
  - If wbm_cyc_i=0 during RESP, the flag is still issued; the master ignores it.
- Response flags are 0 in every state except RESP.
- wbm_dat_o holds its last captured value outside RESP; it is valid only with wbm_ack_o.
- Latency:
  - Master stb sampled at cycle 0 → wbs_stb_o at cycle 1.
  - Slave response at cycle k≥1 → master flag at cycle k+1.
  - Minimum master-visible latency is 2 cycles; throughput is at most one access per 3 cycles.
- Bursts: each beat is one independent classic access; wbs_cti_o=000 and wbs_bte_o=00 always; the master's cti/bte do not alter behaviour.
- Back-to-back: a master still asserting stb in the IDLE cycle after RESP is accepted as a new access.

Optional Feature:
Macro MPSOC_MSI_WB_SLICE_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to REQ and increments each REQ cycle without a response.
  - When counter==TIMEOUT-1 and no response arrives that cycle: drop wbs_cyc_o/stb_o, → RESP with the err flag, and pulse timeout_o for 1 cycle coincident with the next cycle's wbm_err_o.
  - A slave response on the timeout cycle wins: normal response, no timeout.
- Undefined: the counter is absent, REQ waits indefinitely, and timeout_o is tied 0.

Test Plan:
- Reset mid-REQ: access pending, assert wb_rst_i 1 cycle → next cycle all outputs 0, state IDLE, no wbm flag ever issued for that access.
- Single read: adr=0x0000_1000, slave acks at cycle 3 with dat=0xDEAD_BEEF → wbs_stb_o cycles 1-3, wbm_ack_o=1 at cycle 4 only, wbm_dat_o=0xDEAD_BEEF.
- Single write: adr=0x20, dat=0x1234_5678, sel=4'b0011, slave acks at cycle 1 → wbs_dat_o/sel_o/we_o match, wbm_ack_o at cycle 2, wbs_cyc_o=0 at cycle 2.
- Simultaneous err+ack at cycle 2 → only wbm_err_o at cycle 3. rty alone → only wbm_rty_o.
- Abort: master drops cyc at cycle 2, slave silent → wbs_cyc_o=0 at cycle 3, no wbm flag. Burst cti=010 of 4 beats → 4 classic slave accesses, wbs_cti_o=000 throughout.
- Timeout (macro defined, TIMEOUT=8), silent slave: wbs_stb_o cycles 1-8, wbs_cyc_o=0 at cycle 9, wbm_err_o=1 and timeout_o=1 at cycle 10. Macro undefined: stb held 1000 cycles with no flag.
